accelerator_lstm_gate_sequencer: RTL and testbench
==================================================

Name: accelerator_lstm_gate_sequencer

Overview:
Parametrised multi-gate matrix-vector sequencer for the LSTM controller. It loads an input vector once, then for each of G gate channels and each of L rows it streams weights (and optionally biases) and emits y_g[l] = sum_x W_g[l][x]*x[x] + b_g[l] in signed fixed point. It generalises the standard-LSTM controller path with runtime sizes, a gate-channel count, a bias-bypass mode, saturation and size-error reporting. It sits between the stimulus/memory interface and the LSTM activation stage.

Parameters:
DATA_SIZE, 64, data word width (signed two's complement).
CONTROL_SIZE, 64, width of the size and index ports.
FRACTION_SIZE, 32, number of fractional bits of the Q format.
G, 4, gate channel count (input, forget, output, candidate).
X_MAX, 64, depth of the internal x buffer; maximum SIZE_X_IN.

Ports:
CLK  in  1  clock; all logic rising-edge.
RST  in  1  asynchronous, active-low reset.
START  in  1  start pulse; sampled only in IDLE.
READY  out  1  one-cycle pulse at completion or on error.
ERROR  out  1  valid with READY; 1 = illegal size.
MODE  in  1  0 = add bias, 1 = bias bypass; latched at START.
SIZE_X_IN  in  CONTROL_SIZE  vector length; latched at START.
SIZE_L_IN  in  CONTROL_SIZE  rows per gate; latched at START.
X_IN  in  DATA_SIZE  x element.
X_IN_ENABLE  in  1  X_IN valid.
X_OUT_ENABLE  out  1  request for the next x element.
W_IN  in  DATA_SIZE  weight element.
W_IN_ENABLE  in  1  W_IN valid.
W_OUT_ENABLE  out  1  request for the next weight.
B_IN  in  DATA_SIZE  bias element.
B_IN_ENABLE  in  1  B_IN valid.
B_OUT_ENABLE  out  1  request for the next bias.
Y_OUT  out  DATA_SIZE  result.
Y_OUT_ENABLE  out  1  one-cycle Y_OUT valid.
Y_OUT_GATE  out  $clog2(G)  gate index of Y_OUT.
Y_OUT_INDEX  out  CONTROL_SIZE  row index of Y_OUT.

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; all outputs, counters and the accumulator are 0. Reset mid-operation aborts the operation with no READY.
- FSM states are IDLE, LOAD_X, LOAD_B, MAC, EMIT, DONE.
- IDLE, START=1:
  - If SIZE_X_IN=0, SIZE_X_IN>X_MAX or SIZE_L_IN=0, go to DONE with ERROR=1.
  - Otherwise go to LOAD_X.
- Request/response handshake, all three streams:
  - *_OUT_ENABLE is held high while the state needs data.
  - A word is accepted on a cycle with *_IN_ENABLE=1 in the matching state. *_OUT_ENABLE drops the cycle after the last word.
  - *_IN_ENABLE outside the matching state is ignored. Stalls of any length are legal.
- LOAD_X: store SIZE_X_IN words into buffer[0..SIZE_X-1], then go to LOAD_B (MODE=0) or MAC (MODE=1). Gate counter and row counter are cleared.
- LOAD_B: accept one bias word. acc = sign-extended B_IN << FRACTION_SIZE. Go to MAC.
- With MODE=1, acc=0 instead and B_OUT_ENABLE is never asserted.
- MAC: each accepted weight does acc += W_IN*buffer[col] (full 2*DATA_SIZE product). col increments; after col=SIZE_X-1, go to EMIT.
- Accumulator width is 2*DATA_SIZE+$clog2(X_MAX)+1. No wrap is possible.
- EMIT, one cycle after the last weight:
  - Y_OUT = acc >>> FRACTION_SIZE, saturated to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
  - Y_OUT_ENABLE=1 for one cycle, with Y_OUT_GATE and Y_OUT_INDEX set.
  - Then: next row goes to LOAD_B/MAC; the row wraps to 0 with gate+1; after gate G-1 and row L-1, go to DONE.
- Y_OUT holds its value until the next EMIT.
- DONE: READY=1 for one cycle (ERROR per check), then IDLE. ERROR is cleared on the next START.
- START when not IDLE is ignored.
- Emission order is gate-major, then row. x is loaded once per operation.

Decomposition:
- Shared package: state enum, the Q-format saturate and shift function, and the derived width constants (ACC_SIZE, GATE_SIZE).
- One sub-module, accelerator_vector_buffer: an X_MAX x DATA_SIZE register file with write port and combinational read port.

Test Plan:
All scenarios use DATA_SIZE=16, FRACTION_SIZE=8, G=4, X_MAX=8.
- MODE=0, SIZE_X=2, SIZE_L=1, x=[0x0100,0x0200], all W=0x0100, all b=0x0080 -> four Y_OUT=0x0380 with gate 0..3 and index 0; READY=1, ERROR=0 one cycle after the last EMIT.
- Same stimulus with MODE=1 -> B_OUT_ENABLE never high; four Y_OUT=0x0300.
- x=[0x7F00,0x7F00], W=0x7F00 -> Y_OUT=0x7FFF; W=0x8100 -> Y_OUT=0x8000 (saturation).
- SIZE_X=0, then SIZE_X=9 -> no request asserted; READY=1, ERROR=1 two cycles after START.
- Each X_IN_ENABLE delayed by 5 cycles and a START pulse injected in MAC -> X_OUT_ENABLE is held through the stall; results and order are unchanged; no restart.
- RST=0 asserted in MAC -> all outputs 0 immediately; after release, a new START completes scenario 1 correctly.

Source files
------------

// File: rtl/accelerator_lstm_gate_sequencer_pkg.sv
// LSTM gate sequencer shared types and helpers.
// State encoding, derived widths and Q-format saturation.
package accelerator_lstm_gate_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_LOAD_B,
    S_MAC,
    S_EMIT,
    S_DONE
  } state_e;

  localparam int SAT_W = 256;

  function automatic int acc_size(
    input int dw,
    input int xmax
  );
    return 2 * dw + $clog2(xmax) + 1;
  endfunction

  function automatic int gate_size(input int g);
    return (g > 1) ? $clog2(g) : 1;
  endfunction

  // Arithmetic shift out the fraction, then clamp to dw bits.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] a,
    input int frac,
    input int dw
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    s  = a >>> frac;
    hi = (256'sd1 <<< (dw - 1)) - 256'sd1;
    lo = -(256'sd1 <<< (dw - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/accelerator_lstm_gate_sequencer_if.sv
// LSTM gate sequencer control and stream bundle.
// master = stimulus/memory side, slave = sequencer.
interface accelerator_lstm_gate_sequencer_if
  import accelerator_lstm_gate_sequencer_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int G            = 4
);
  localparam int GATE_SIZE = gate_size(G);

  logic                    START;
  logic                    READY;
  logic                    ERROR;
  logic                    MODE;
  logic [CONTROL_SIZE-1:0] SIZE_X_IN;
  logic [CONTROL_SIZE-1:0] SIZE_L_IN;
  logic [DATA_SIZE-1:0]    X_IN;
  logic                    X_IN_ENABLE;
  logic                    X_OUT_ENABLE;
  logic [DATA_SIZE-1:0]    W_IN;
  logic                    W_IN_ENABLE;
  logic                    W_OUT_ENABLE;
  logic [DATA_SIZE-1:0]    B_IN;
  logic                    B_IN_ENABLE;
  logic                    B_OUT_ENABLE;
  logic [DATA_SIZE-1:0]    Y_OUT;
  logic                    Y_OUT_ENABLE;
  logic [GATE_SIZE-1:0]    Y_OUT_GATE;
  logic [CONTROL_SIZE-1:0] Y_OUT_INDEX;

  modport master (
    output START, MODE, SIZE_X_IN, SIZE_L_IN,
    output X_IN, X_IN_ENABLE,
    output W_IN, W_IN_ENABLE,
    output B_IN, B_IN_ENABLE,
    input  READY, ERROR,
    input  X_OUT_ENABLE, W_OUT_ENABLE, B_OUT_ENABLE,
    input  Y_OUT, Y_OUT_ENABLE, Y_OUT_GATE, Y_OUT_INDEX
  );

  modport slave (
    input  START, MODE, SIZE_X_IN, SIZE_L_IN,
    input  X_IN, X_IN_ENABLE,
    input  W_IN, W_IN_ENABLE,
    input  B_IN, B_IN_ENABLE,
    output READY, ERROR,
    output X_OUT_ENABLE, W_OUT_ENABLE, B_OUT_ENABLE,
    output Y_OUT, Y_OUT_ENABLE, Y_OUT_GATE, Y_OUT_INDEX
  );

endinterface

// File: rtl/accelerator_lstm_gate_sequencer_vector_buffer.sv
// x vector register file for the gate sequencer.
// One write port, one combinational read port.
module accelerator_vector_buffer #(
  parameter int DEPTH     = 64,
  parameter int WIDTH     = 64,
  parameter int ADDR_SIZE = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store an accepted x element.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/accelerator_lstm_gate_sequencer.sv
// Multi-gate matrix-vector sequencer for the LSTM controller.
// Loads x once, then emits W_g*x (+b_g) per gate and row.
module accelerator_lstm_gate_sequencer
  import accelerator_lstm_gate_sequencer_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 64,
  parameter int FRACTION_SIZE = 32,
  parameter int G             = 4,
  parameter int X_MAX         = 64
) (
  input logic CLK,
  input logic RST,
  accelerator_lstm_gate_sequencer_if.slave bus
);

  localparam int ACC_SIZE  = acc_size(DATA_SIZE, X_MAX);
  localparam int GATE_SIZE = gate_size(G);
  localparam int IDX_SIZE  = (X_MAX > 1) ? $clog2(X_MAX) : 1;
  localparam int PROD_SIZE = 2 * DATA_SIZE;

  state_e state, state_nx;

  logic                       mode;
  logic [IDX_SIZE-1:0]        col;
  logic [IDX_SIZE-1:0]        size_x_m1;
  logic [CONTROL_SIZE-1:0]    row;
  logic [CONTROL_SIZE-1:0]    size_l_m1;
  logic [GATE_SIZE-1:0]       gate;
  logic signed [ACC_SIZE-1:0] acc;

  logic [DATA_SIZE-1:0]    y_q;
  logic                    y_en_q;
  logic [GATE_SIZE-1:0]    y_gate_q;
  logic [CONTROL_SIZE-1:0] y_idx_q;
  logic                    ready_q;
  logic                    error_q;

  logic                        bad_size;
  logic                        x_acc, b_acc, w_acc;
  logic                        col_last, row_last, gate_last;
  logic [DATA_SIZE-1:0]        x_rd;
  logic signed [PROD_SIZE-1:0] prod;
  logic signed [ACC_SIZE-1:0]  prod_ext;
  logic signed [ACC_SIZE-1:0]  bias_ext;
  logic [DATA_SIZE-1:0]        y_sat;

  accelerator_vector_buffer #(
    .DEPTH (X_MAX),
    .WIDTH (DATA_SIZE)
  ) u_xbuf (
    .clk   (CLK),
    .we    (x_acc),
    .waddr (col),
    .wdata (bus.X_IN),
    .raddr (col),
    .rdata (x_rd)
  );

  assign bad_size = (bus.SIZE_X_IN == '0)
    || (bus.SIZE_X_IN > CONTROL_SIZE'(X_MAX))
    || (bus.SIZE_L_IN == '0);

  assign x_acc = (state == S_LOAD_X) && bus.X_IN_ENABLE;
  assign b_acc = (state == S_LOAD_B) && bus.B_IN_ENABLE;
  assign w_acc = (state == S_MAC) && bus.W_IN_ENABLE;

  assign col_last  = (col == size_x_m1);
  assign row_last  = (row == size_l_m1);
  assign gate_last = (gate == GATE_SIZE'(G - 1));

  assign prod = PROD_SIZE'($signed(bus.W_IN))
              * PROD_SIZE'($signed(x_rd));
  assign prod_ext = ACC_SIZE'(prod);
  assign bias_ext =
    ACC_SIZE'($signed(bus.B_IN)) <<< FRACTION_SIZE;
  assign y_sat = DATA_SIZE'(
    sat_shift(SAT_W'(acc), FRACTION_SIZE, DATA_SIZE));

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (bus.START)
          state_nx = bad_size ? S_DONE : S_LOAD_X;
      S_LOAD_X:
        if (x_acc && col_last)
          state_nx = mode ? S_MAC : S_LOAD_B;
      S_LOAD_B:
        if (b_acc) state_nx = S_MAC;
      S_MAC:
        if (w_acc && col_last) state_nx = S_EMIT;
      S_EMIT:
        if (row_last && gate_last) state_nx = S_DONE;
        else state_nx = mode ? S_MAC : S_LOAD_B;
      S_DONE:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // Counters, accumulator and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mode      <= 1'b0;
      col       <= '0;
      size_x_m1 <= '0;
      row       <= '0;
      size_l_m1 <= '0;
      gate      <= '0;
      acc       <= '0;
      y_q       <= '0;
      y_en_q    <= 1'b0;
      y_gate_q  <= '0;
      y_idx_q   <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      y_en_q  <= 1'b0;
      ready_q <= 1'b0;
      unique case (state)
        S_IDLE: if (bus.START) begin
          mode      <= bus.MODE;
          size_x_m1 <= IDX_SIZE'(
            bus.SIZE_X_IN - CONTROL_SIZE'(1));
          size_l_m1 <=
            bus.SIZE_L_IN - CONTROL_SIZE'(1);
          col       <= '0;
          error_q   <= bad_size;
        end
        S_LOAD_X: if (x_acc) begin
          col <= col_last ? '0 : col + IDX_SIZE'(1);
          if (col_last) begin
            row  <= '0;
            gate <= '0;
            acc  <= '0;
          end
        end
        S_LOAD_B: if (b_acc) acc <= bias_ext;
        S_MAC: if (w_acc) begin
          acc <= acc + prod_ext;
          col <= col_last ? '0 : col + IDX_SIZE'(1);
        end
        S_EMIT: begin
          y_q      <= y_sat;
          y_en_q   <= 1'b1;
          y_gate_q <= gate;
          y_idx_q  <= row;
          acc      <= '0;
          if (row_last) begin
            row  <= '0;
            gate <= gate + GATE_SIZE'(1);
          end else begin
            row <= row + CONTROL_SIZE'(1);
          end
        end
        S_DONE: ready_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.X_OUT_ENABLE = (state == S_LOAD_X);
  assign bus.B_OUT_ENABLE = (state == S_LOAD_B);
  assign bus.W_OUT_ENABLE = (state == S_MAC);
  assign bus.Y_OUT        = y_q;
  assign bus.Y_OUT_ENABLE = y_en_q;
  assign bus.Y_OUT_GATE   = y_gate_q;
  assign bus.Y_OUT_INDEX  = y_idx_q;
  assign bus.READY        = ready_q;
  assign bus.ERROR        = error_q;

endmodule

// File: tb/tb_accelerator_lstm_gate_sequencer.sv
// Self-checking bench for the LSTM gate sequencer.
// Expected rows are queued at start and popped on Y_OUT_ENABLE.
module tb_accelerator_lstm_gate_sequencer;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int F  = 8;
  localparam int G  = 4;
  localparam int XM = 8;
  localparam int LM = 4;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  accelerator_lstm_gate_sequencer_if #(
    .DATA_SIZE (DW),
    .CONTROL_SIZE (CW),
    .G (G)
  ) bus ();

  accelerator_lstm_gate_sequencer #(
    .DATA_SIZE (DW),
    .CONTROL_SIZE (CW),
    .FRACTION_SIZE (F),
    .G (G),
    .X_MAX (XM)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb [$];

  int xv [XM];
  int w_tab [G][LM][XM];
  int b_tab [G][LM];

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_y(
    input int g, input int r, input int sx, input bit md
  );
    longint acc;
    acc = md ? 64'sd0 : (longint'(b_tab[g][r]) <<< F);
    for (int c = 0; c < sx; c++)
      acc += longint'(w_tab[g][r][c]) * longint'(xv[c]);
    acc = acc >>> F;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  function automatic logic [39:0] outs();
    return {bus.Y_OUT, bus.Y_OUT_ENABLE, bus.READY,
            bus.ERROR, bus.X_OUT_ENABLE,
            bus.W_OUT_ENABLE, bus.B_OUT_ENABLE,
            bus.Y_OUT_GATE, bus.Y_OUT_INDEX};
  endfunction

  task automatic fill_const(
    input int x0, input int x1, input int wlo,
    input int whi, input int b
  );
    for (int i = 0; i < XM; i++)
      xv[i] = (i % 2 == 0) ? x0 : x1;
    for (int g = 0; g < G; g++)
      for (int r = 0; r < LM; r++) begin
        b_tab[g][r] = b;
        for (int c = 0; c < XM; c++)
          w_tab[g][r][c] = (g < 2) ? wlo : whi;
      end
  endtask

  task automatic fill_rand();
    logic [15:0] t;
    for (int i = 0; i < XM; i++) begin
      t = 16'($urandom);
      xv[i] = int'($signed(t));
    end
    for (int g = 0; g < G; g++)
      for (int r = 0; r < LM; r++) begin
        t = 16'($urandom);
        b_tab[g][r] = int'($signed(t));
        for (int c = 0; c < XM; c++) begin
          t = 16'($urandom);
          w_tab[g][r][c] = int'($signed(t));
        end
      end
  endtask

  task automatic run_op(
    input  bit md, input int sx, input int sl,
    input  int xdly, input bit inj, input bit abort,
    output bit rdy, output bit err,
    output int rdy_cyc, output int last_y,
    output bit b_seen, output bit any_req,
    output int nx
  );
    int wg, wr, wc, bg, br, stall;
    bit injected, ab;
    rdy = 0; err = 0; rdy_cyc = 0; last_y = 0;
    b_seen = 0; any_req = 0; nx = 0;
    wg = 0; wr = 0; wc = 0; bg = 0; br = 0;
    stall = 0; injected = 0; ab = 0;
    if (sx >= 1 && sx <= XM && sl >= 1)
      for (int g = 0; g < G; g++)
        for (int r = 0; r < sl; r++)
          sb.push_back({30'b0, 2'(g), 16'(r),
                        model_y(g, r, sx, md)});
    @(negedge CLK);
    bus.START = 1'b1;
    bus.MODE = md;
    bus.SIZE_X_IN = 16'(sx);
    bus.SIZE_L_IN = 16'(sl);
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge CLK);
      bus.START = 1'b0;
      bus.X_IN_ENABLE = 1'b0;
      bus.W_IN_ENABLE = 1'b0;
      bus.B_IN_ENABLE = 1'b0;
      if (bus.X_OUT_ENABLE || bus.W_OUT_ENABLE
          || bus.B_OUT_ENABLE) any_req = 1;
      if (bus.B_OUT_ENABLE) b_seen = 1;
      if (bus.Y_OUT_ENABLE) begin
        last_y = cyc;
        if (sb.size() == 0) chk("y_extra", 1, 0);
        else chk("y", {30'b0, bus.Y_OUT_GATE,
                 bus.Y_OUT_INDEX, bus.Y_OUT},
                 sb.pop_front());
      end
      if (bus.READY) begin
        rdy = 1; err = bus.ERROR; rdy_cyc = cyc;
        break;
      end
      if (abort && bus.W_OUT_ENABLE && wg == 1) begin
        RST = 1'b0;
        #1;
        chk("rst_outs", 64'(outs()), 0);
        sb.delete();
        @(negedge CLK);
        RST = 1'b1;
        ab = 1;
        break;
      end
      if (bus.X_OUT_ENABLE) begin
        if (stall < xdly) stall++;
        else begin
          stall = 0;
          bus.X_IN_ENABLE = 1'b1;
          bus.X_IN = 16'(xv[nx % XM]);
          nx++;
        end
      end else if (xdly > 0) begin
        bus.X_IN_ENABLE = 1'b1;
        bus.X_IN = 16'h5a5a;
      end
      if (bus.W_OUT_ENABLE) begin
        bus.W_IN_ENABLE = 1'b1;
        bus.W_IN = 16'(w_tab[wg % G][wr % LM][wc % XM]);
        wc++;
        if (wc == sx) begin wc = 0; wr++; end
        if (wr == sl) begin wr = 0; wg++; end
        if (inj && !injected) begin
          bus.START = 1'b1;
          bus.SIZE_X_IN = 16'd1;
          injected = 1;
        end
      end else if (xdly > 0) begin
        bus.W_IN_ENABLE = 1'b1;
        bus.W_IN = 16'h7fff;
      end
      if (bus.B_OUT_ENABLE) begin
        bus.B_IN_ENABLE = 1'b1;
        bus.B_IN = 16'(b_tab[bg % G][br % LM]);
        br++;
        if (br == sl) begin br = 0; bg++; end
      end else if (xdly > 0) begin
        bus.B_IN_ENABLE = 1'b1;
        bus.B_IN = 16'h7fff;
      end
    end
    if (!rdy && !ab) chk("timeout", 0, 1);
  endtask

  task automatic check_ok(
    input string tag, input bit md, input int sx,
    input int sl, input int xdly, input bit inj
  );
    bit rdy, err, bs, ar;
    int rc, ly, nx;
    run_op(md, sx, sl, xdly, inj, 0,
           rdy, err, rc, ly, bs, ar, nx);
    chk({tag, "_ready"}, 64'(rdy), 1);
    chk({tag, "_error"}, 64'(err), 0);
    chk({tag, "_lat"}, 64'(rc), 64'(ly + 1));
    chk({tag, "_sb_left"}, 64'(sb.size()), 0);
    chk({tag, "_nx"}, 64'(nx), 64'(sx));
    if (md) chk({tag, "_b_req"}, 64'(bs), 0);
  endtask

  task automatic check_bad(
    input string tag, input int sx, input int sl
  );
    bit rdy, err, bs, ar;
    int rc, ly, nx;
    run_op(0, sx, sl, 0, 0, 0,
           rdy, err, rc, ly, bs, ar, nx);
    chk({tag, "_ready"}, 64'(rdy), 1);
    chk({tag, "_error"}, 64'(err), 1);
    chk({tag, "_lat"}, 64'(rc), 2);
    chk({tag, "_req"}, 64'(ar), 0);
  endtask

  initial begin
    bit rdy, err, bs, ar, seen;
    int rc, ly, nx;
    RST = 1'b0;
    bus.START = 0; bus.MODE = 0;
    bus.SIZE_X_IN = '0; bus.SIZE_L_IN = '0;
    bus.X_IN = '0; bus.X_IN_ENABLE = 0;
    bus.W_IN = '0; bus.W_IN_ENABLE = 0;
    bus.B_IN = '0; bus.B_IN_ENABLE = 0;
    repeat (2) @(negedge CLK);
    chk("reset_outs", 64'(outs()), 0);
    RST = 1'b1;

    fill_const(32'h0100, 32'h0200, 32'h0100,
               32'h0100, 32'h0080);
    check_ok("s1_bias", 0, 2, 1, 0, 0);
    check_ok("s2_bypass", 1, 2, 1, 0, 0);

    fill_const(32'h7f00, 32'h7f00, 32'h7f00,
               int'(16'sh8100), 32'h0080);
    check_ok("s3_sat", 1, 2, 1, 0, 0);
    check_ok("s3_sat_b", 0, 2, 2, 0, 0);

    check_bad("e_x0", 0, 1);
    check_bad("e_x9", 9, 1);
    check_bad("e_l0", 2, 0);

    fill_const(32'h0100, 32'h0200, 32'h0100,
               32'h0100, 32'h0080);
    check_ok("s5_stall", 0, 2, 2, 5, 1);
    seen = 0;
    repeat (4) begin
      @(negedge CLK);
      seen |= bus.X_OUT_ENABLE | bus.W_OUT_ENABLE
            | bus.READY;
    end
    chk("s5_no_restart", 64'(seen), 0);

    fill_rand();
    check_ok("s6_rand", 0, XM, 3, 0, 0);
    fill_rand();
    check_ok("s6_rand_byp", 1, 1, 2, 2, 0);

    fill_const(32'h0100, 32'h0200, 32'h0100,
               32'h0100, 32'h0080);
    run_op(0, 2, 1, 0, 0, 1,
           rdy, err, rc, ly, bs, ar, nx);
    chk("s7_abort_ready", 64'(rdy), 0);
    seen = 0;
    repeat (4) begin
      @(negedge CLK);
      seen |= bus.READY | bus.W_OUT_ENABLE;
    end
    chk("s7_idle_after_rst", 64'(seen), 0);
    check_ok("s7_rerun", 0, 2, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
